// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Width codes follow the RV32I funct3 encoding for loads and stores.
package lsu_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_READ = 2'd1,
    RESP      = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] byte_enable_for(input logic [2:0] funct3);
    logic [3:0] be;
    case (funct3)
      MEM_B, MEM_BU: be = 4'b0001;
      MEM_H, MEM_HU: be = 4'b0011;
      MEM_W:         be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      MEM_H, MEM_HU: mis = addr_lo[0];
      MEM_W:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Single-port byte-addressed cache interface; read data is registered by the cache
// and valid the cycle after an enabled read.
interface lsu_mem_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                      enable;
  logic                      write_enable;
  logic [ADDRESS_WIDTH-1:0]  address;
  logic [DATA_WIDTH/8-1:0]   byte_enable;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH-1:0]     read_data;

  modport master (
    output enable, write_enable, address, byte_enable, write_data,
    input  read_data
  );

  modport slave (
    input  enable, write_enable, address, byte_enable, write_data,
    output read_data
  );
endinterface

// File: rtl/load_extend.sv
// Width selection and sign/zero extension of raw cache read data.
// Purely combinational.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] read_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = '0;
    case (funct3)
      MEM_B:   ext_data = {{24{read_data[7]}}, read_data[7:0]};
      MEM_H:   ext_data = {{16{read_data[15]}}, read_data[15:0]};
      MEM_W:   ext_data = read_data;
      MEM_BU:  ext_data = {24'd0, read_data[7:0]};
      MEM_HU:  ext_data = {16'd0, read_data[15:0]};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of the data cache: one request at a time, store/fault respond
// at N+1, loads at N+2; response held in RESP until resp_ready, no new request accepted meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_store_data,
  input  logic [4:0]               req_rd,

  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic [4:0]               resp_rd,
  output logic                     resp_is_store,
  output logic                     resp_misaligned,
  output logic                     resp_illegal,

  lsu_mem_if.master                mem
);

  lsu_state_e            state_q;
  logic [2:0]            funct3_q;
  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  fault;
  logic                  mem_access;
  logic [DATA_WIDTH-1:0] ext_data;

  // Gated by reset_n so nothing is accepted while the unit is held in reset.
  assign req_ready  = reset_n && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  assign illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
  assign misaligned = !illegal && is_misaligned(req_funct3, req_address[1:0]);
  assign fault      = illegal || misaligned;
  assign mem_access = accept && !fault;

  // Lanes are not shifted: the cache maps write_data byte i to address+i.
  assign mem.enable       = mem_access;
  assign mem.write_enable = mem_access && req_is_store;
  assign mem.address      = mem_access ? req_address : '0;
  assign mem.byte_enable  = mem_access ? byte_enable_for(req_funct3) : '0;
  assign mem.write_data   = mem_access ? req_store_data : '0;

  load_extend u_load_extend (
    .funct3    (funct3_q),
    .read_data (mem.read_data),
    .ext_data  (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      funct3_q        <= '0;
      resp_data       <= '0;
      resp_rd         <= '0;
      resp_is_store   <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q        <= req_funct3;
            resp_data       <= '0;
            resp_rd         <= req_rd;
            resp_is_store   <= req_is_store;
            resp_misaligned <= misaligned;
            resp_illegal    <= illegal;
            state_q         <= (fault || req_is_store) ? RESP : WAIT_READ;
          end
        end
        WAIT_READ: begin
          resp_data <= ext_data;
          state_q   <= RESP;
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the data cache.
- Accepts one load/store request at a time from execute over a valid/ready handshake, checks alignment and operation code, and drives the cache's single byte-addressed port (MemoryInterfaceSinglePort, master side).
- Captures the cache's registered read data and applies width selection and sign/zero extension.
- Returns exactly one response per request to writeback over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, data path width; fixed at 32 (4 byte lanes).
- ADDRESS_WIDTH, 32, width of the byte address driven to the cache.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute has a memory request
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_address  in  ADDRESS_WIDTH  byte address
- req_store_data  in  DATA_WIDTH  store source data, least-significant bytes used
- req_rd  in  5  load destination register tag
- resp_valid  out  1  response available
- resp_ready  in  1  writeback consumes response
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and faults
- resp_rd  out  5  echoed req_rd
- resp_is_store  out  1  echoed req_is_store
- resp_misaligned  out  1  alignment fault, no memory access performed
- resp_illegal  out  1  invalid funct3, no memory access performed
- mem  master  modport  enable, write_enable, address, byte_enable[3:0], write_data (out); read_data (in)

Behaviour:
- Clock and reset: clk is the only clock. reset_n is asynchronous and active-low.
- Reset values: state IDLE; resp_valid 0; resp_data, resp_rd, resp_is_store, resp_misaligned and resp_illegal all 0. While reset_n is low, mem.enable and req_ready are 0.
- States:
  - IDLE: req_ready=1.
  - WAIT_READ: load in flight; req_ready=0.
  - RESP: response held; req_ready=0.
- Accept: fires on req_valid && req_ready in IDLE. All mem outputs are driven combinationally from the request during the accept cycle only. In every other cycle mem.enable=0.
- Fault checks (combinational, at accept):
  - Illegal: funct3 ∈ {011, 110, 111}, or a store with funct3[2]=1.
  - Misaligned: H/HU with address[0]≠0, or W with address[1:0]≠0.
  - Illegal takes priority; only one flag is ever set.
  - On any fault, mem.enable stays 0.
- Byte enables: B/BU → 0001, H/HU → 0011, W → 1111.
  - The cache is byte-addressed and maps write_data[8i+:8] to address+i, so no lane shifting is applied.
  - mem.address = req_address; mem.write_data = req_store_data.
- Store or fault: mem.write_enable = req_is_store (stores only). Next state is RESP; the response is registered at the accept edge.
  - Latency: resp_valid is asserted in cycle N+1 for accept cycle N.
- Load: mem.enable=1, write_enable=0, next state WAIT_READ.
  - mem.read_data is valid during WAIT_READ, since the cache registers its read.
  - At the end of WAIT_READ the extended value is registered into resp_data and the state moves to RESP.
  - Latency: resp_valid is asserted at N+2.
- Extension, from read_data[7:0] or [15:0]: B sign-extends bits 7:0; H sign-extends bits 15:0; BU/HU zero-extend; W passes through.
- RESP: resp_valid=1 with all resp fields stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid drops next cycle and the state returns to IDLE.
  - No new request is accepted in the handshake cycle; req_ready rises the following cycle.
- Backpressure: resp_ready held low keeps the unit in RESP indefinitely. No second memory access is issued.
- Reset mid-operation:
  - Immediate return to IDLE and the pending response is discarded.
  - A store whose accept edge has already occurred has committed in the cache; it is not rolled back.
- Address range: no bounds checking; wrap beyond the cache depth is the cache's concern.

Decomposition:
- Shared package lsu_pkg:
  - mem_width_e enum (funct3 codes)
  - lsu_state_e (IDLE, WAIT_READ, RESP)
  - function byte_enable_for(funct3)
  - function is_misaligned(funct3, addr[1:0])
- One combinational sub-module, load_extend: inputs funct3 and read_data, output extended word.

Test Plan:
- LW at address 0x8 after SW 0xDEADBEEF at 0x8 → store: byte_enable 1111, resp_valid at N+1. Load: resp_valid at N+2, resp_data 0xDEADBEEF, resp_rd echoed.
- SB 0x000000F0 at 0x5, then LB at 0x5 and LBU at 0x5 → LB resp_data 0xFFFFFFF0; LBU 0x000000F0. Byte_enable 0001 on the store; neighbouring bytes unchanged.
- LH at 0x3 and SW at 0x2 → resp_misaligned=1, resp_data 0, mem.enable never asserted, resp_valid at N+1.
- Load funct3=011 and store funct3=100 → resp_illegal=1, resp_misaligned=0, no memory access.
- LHU 0x8001 with resp_ready held low for 5 cycles → resp_valid and resp_data 0x00008001 stable throughout, req_ready=0, no mem.enable. Handshake then IDLE; next request is accepted 1 cycle later.
- Assert reset_n low during WAIT_READ → resp_valid 0 immediately; after release the unit is IDLE with req_ready=1, and a following LW returns correct data.
